// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RESP,
        DRAIN
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LSU
    } arb_owner_t;

    localparam int DEFAULT_ARB_TIMEOUT = 16;

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Combinational winner selection between fetch and LSU requests.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternate on ties using last_winner),
// otherwise fixed priority with the LSU always beating fetch.
module mem_arb_picker
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req_i,
    input  logic       lsu_req_i,
    input  arb_owner_t last_winner_i,
    output arb_owner_t winner_o
);

    // On a tie, 1 selects the LSU and 0 selects fetch.
    logic tie_pick_lsu;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_pick_lsu = (last_winner_i != OWN_LSU);
`else
    // last_winner deliberately has no influence in fixed-priority builds.
    assign tie_pick_lsu = 1'b1 | (last_winner_i == OWN_LSU);
`endif

    // Pick the winner from the current requests.
    always_comb begin
        winner_o = OWN_NONE;
        if (if_req_i && lsu_req_i) begin
            winner_o = tie_pick_lsu ? OWN_LSU : OWN_FETCH;
        end else if (lsu_req_i) begin
            winner_o = OWN_LSU;
        end else if (if_req_i) begin
            winner_o = OWN_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the LSU.
// One transaction outstanding at a time; a missing response becomes an error
// completion after TIMEOUT_CYCLES, and the late response is then drained.
// Optional build macro: ARB_ROUND_ROBIN_EN (see mem_arb_picker).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_ARB_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        srst_i,
    // fetch side
    input  logic        if_req_ip,
    input  logic [31:0] if_addr_ip,
    output logic        if_gnt_op,
    output logic        if_rvalid_op,
    output logic        if_err_op,
    output logic [31:0] if_rdata_op,
    // LSU side
    input  logic        lsu_req_ip,
    input  logic        lsu_we_ip,
    input  logic [3:0]  lsu_be_ip,
    input  logic [31:0] lsu_addr_ip,
    input  logic [31:0] lsu_wdata_ip,
    output logic        lsu_gnt_op,
    output logic        lsu_rvalid_op,
    output logic        lsu_err_op,
    output logic [31:0] lsu_rdata_op,
    // memory side
    output logic        mem_req_op,
    output logic        mem_we_op,
    output logic [3:0]  mem_be_op,
    output logic [31:0] mem_addr_op,
    output logic [31:0] mem_wdata_op,
    input  logic        mem_gnt_ip,
    input  logic        mem_rvalid_ip,
    input  logic [31:0] mem_rdata_ip
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    arb_state_t         state_q, state_d;
    arb_owner_t         owner_q, owner_d;
    arb_owner_t         last_winner_q, last_winner_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    arb_owner_t         winner;
    logic               resp_valid;
    logic               resp_err;
    logic [31:0]        resp_data;

    mem_arb_picker u_picker (
        .if_req_i      (if_req_ip),
        .lsu_req_i     (lsu_req_ip),
        .last_winner_i (last_winner_q),
        .winner_o      (winner)
    );

    // State, owner, winner history and response timer registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q       <= IDLE;
            owner_q       <= OWN_NONE;
            last_winner_q <= OWN_FETCH;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            timer_q       <= timer_d;
        end
    end

    // Next-state logic, memory request drive and response routing.
    // Outputs are held at zero during reset so no grant can be issued that
    // the state registers would then forget.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        timer_d       = timer_q;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;
        if_gnt_op     = 1'b0;
        lsu_gnt_op    = 1'b0;
        mem_req_op    = 1'b0;
        mem_we_op     = 1'b0;
        mem_be_op     = 4'h0;
        mem_addr_op   = '0;
        mem_wdata_op  = '0;
        if_rvalid_op  = 1'b0;
        if_err_op     = 1'b0;
        if_rdata_op   = '0;
        lsu_rvalid_op = 1'b0;
        lsu_err_op    = 1'b0;
        lsu_rdata_op  = '0;

        if (!srst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (winner == OWN_LSU) begin
                        mem_req_op   = 1'b1;
                        mem_we_op    = lsu_we_ip;
                        mem_be_op    = lsu_be_ip;
                        mem_addr_op  = lsu_addr_ip;
                        mem_wdata_op = lsu_wdata_ip;
                    end else if (winner == OWN_FETCH) begin
                        mem_req_op   = 1'b1;
                        mem_we_op    = 1'b0;
                        mem_be_op    = 4'hF;
                        mem_addr_op  = if_addr_ip;
                        mem_wdata_op = '0;
                    end
                    // Grant only when memory accepts; otherwise re-arbitrate next cycle.
                    if (mem_req_op && mem_gnt_ip) begin
                        if_gnt_op     = (winner == OWN_FETCH);
                        lsu_gnt_op    = (winner == OWN_LSU);
                        owner_d       = winner;
                        last_winner_d = winner;
                        timer_d       = '0;
                        state_d       = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A real response beats a coincident timeout.
                    if (mem_rvalid_ip) begin
                        resp_valid = 1'b1;
                        resp_data  = mem_rdata_ip;
                        state_d    = IDLE;
                    end else if (timer_q == TIMER_LIMIT) begin
                        resp_valid = 1'b1;
                        resp_err   = 1'b1;
                        state_d    = DRAIN;
                    end else if (timer_q < TIMER_LIMIT) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Swallow the late response; nobody sees it.
                    if (mem_rvalid_ip) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (resp_valid) begin
                if (owner_q == OWN_FETCH) begin
                    if_rvalid_op = 1'b1;
                    if_err_op    = resp_err;
                    if_rdata_op  = resp_data;
                end else if (owner_q == OWN_LSU) begin
                    lsu_rvalid_op = 1'b1;
                    lsu_err_op    = resp_err;
                    lsu_rdata_op  = resp_data;
                end
                owner_d = OWN_NONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        srst;
    logic        if_req, lsu_req, lsu_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [3:0]  lsu_be;

    logic        if_gnt, if_rvalid, if_err, lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] if_rdata, lsu_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .if_req_ip     (if_req),
        .if_addr_ip    (if_addr),
        .if_gnt_op     (if_gnt),
        .if_rvalid_op  (if_rvalid),
        .if_err_op     (if_err),
        .if_rdata_op   (if_rdata),
        .lsu_req_ip    (lsu_req),
        .lsu_we_ip     (lsu_we),
        .lsu_be_ip     (lsu_be),
        .lsu_addr_ip   (lsu_addr),
        .lsu_wdata_ip  (lsu_wdata),
        .lsu_gnt_op    (lsu_gnt),
        .lsu_rvalid_op (lsu_rvalid),
        .lsu_err_op    (lsu_err),
        .lsu_rdata_op  (lsu_rdata),
        .mem_req_op    (mem_req),
        .mem_we_op     (mem_we),
        .mem_be_op     (mem_be),
        .mem_addr_op   (mem_addr),
        .mem_wdata_op  (mem_wdata),
        .mem_gnt_ip    (mem_gnt),
        .mem_rvalid_ip (mem_rvalid),
        .mem_rdata_ip  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model: is a transaction outstanding, who owns it, how
    // many cycles since its grant, are we discarding a late response, and who
    // won last (0 = fetch, 1 = LSU).
    bit m_pend, m_drain;
    int m_own, m_age, m_lw;
    bit g_if, g_lsu;   // grants the model expected in the last checked cycle

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Derive this cycle's expected outputs from the model, compare, then
    // advance the model to what it must look like after the coming edge.
    task automatic model_check();
        logic        e_ig, e_lg, e_rv, e_er;
        logic [31:0] e_rd;
        logic        e_mreq, e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_maddr, e_mwd;
        int          w;
        e_ig = 0; e_lg = 0; e_rv = 0; e_er = 0; e_rd = 0;
        e_mreq = 0; e_mwe = 0; e_mbe = 0; e_maddr = 0; e_mwd = 0;
        w = -1;
        if (srst) begin
            m_pend = 0; m_drain = 0; m_lw = 0; m_age = 0;
        end else if (m_drain) begin
            if (mem_rvalid) m_drain = 0;
        end else if (m_pend) begin
            if (mem_rvalid) begin
                e_rv = 1; e_rd = mem_rdata; m_pend = 0;
            end else if (m_age == TMO + 1) begin
                e_rv = 1; e_er = 1; m_pend = 0; m_drain = 1;
            end else begin
                m_age++;
            end
        end else begin
            if (if_req && lsu_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = (m_lw == 1) ? 0 : 1;
`else
                w = 1;
`endif
            end else if (lsu_req) w = 1;
            else if (if_req) w = 0;
            if (w == 1) begin
                e_mreq = 1; e_mwe = lsu_we; e_mbe = lsu_be; e_maddr = lsu_addr; e_mwd = lsu_wdata;
            end else if (w == 0) begin
                e_mreq = 1; e_mbe = 4'hF; e_maddr = if_addr;
            end
            if (w >= 0 && mem_gnt) begin
                e_ig = (w == 0); e_lg = (w == 1);
                m_pend = 1; m_own = w; m_lw = w; m_age = 1;
            end
        end
        chk("grants", {if_gnt, lsu_gnt}, {e_ig, e_lg});
        chk("mem_side", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
            {e_mreq, e_mwe, e_mbe, e_maddr, e_mwd});
        if (e_rv && m_own == 0)
            chk("if_resp", {if_rvalid, if_err, if_rdata}, {1'b1, e_er, e_rd});
        else
            chk("if_resp", {if_rvalid, if_err, if_rdata}, 34'h0);
        if (e_rv && m_own == 1)
            chk("lsu_resp", {lsu_rvalid, lsu_err, lsu_rdata}, {1'b1, e_er, e_rd});
        else
            chk("lsu_resp", {lsu_rvalid, lsu_err, lsu_rdata}, 34'h0);
        g_if = e_ig;
        g_lsu = e_lg;
    endtask

    task automatic end_cyc();
        model_check();
        @(negedge clk);
    endtask

    task automatic cyc();
        #1;
        end_cyc();
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; lsu_req = 0; lsu_we = 0; lsu_be = 0;
        lsu_addr = 0; lsu_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    logic [2:0] tie_pat;

    initial begin
        clear_inputs();
        srst = 1;
        m_pend = 0; m_drain = 0; m_own = 0; m_age = 0; m_lw = 0; g_if = 0; g_lsu = 0;
        @(negedge clk);
        cyc();
        srst = 0;
        #1;
        chk("reset_outputs", {if_gnt, if_rvalid, if_err, if_rdata, lsu_gnt, lsu_rvalid, lsu_err,
                              lsu_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
        end_cyc();

        // Lone LSU load to 0x100, response two cycles after grant.
        lsu_req = 1; lsu_addr = 32'h100; lsu_be = 4'hF; mem_gnt = 1;
        #1;
        chk("lsu_load_gnt", {lsu_gnt, if_gnt, mem_req, mem_addr}, {1'b1, 1'b0, 1'b1, 32'h100});
        end_cyc();
        lsu_req = 0; mem_gnt = 0;
        cyc();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("lsu_load_resp", {lsu_rvalid, lsu_err, lsu_rdata, if_rvalid, if_rdata},
            {1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0});
        end_cyc();
        mem_rvalid = 0;
        cyc();

        // Fresh reset, then both requesting with mem_gnt held high.
        srst = 1;
        cyc();
        srst = 0;
`ifdef ARB_ROUND_ROBIN_EN
        tie_pat = 3'b101;
`else
        tie_pat = 3'b111;
`endif
        if_req = 1; if_addr = 32'h80; lsu_req = 1; lsu_addr = 32'h90; mem_gnt = 1;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 0;
            #1;
            chk("tie_winner", {lsu_gnt, if_gnt}, {tie_pat[k], ~tie_pat[k]});
            end_cyc();
            mem_rvalid = 1; mem_rdata = 32'h1000 + k;
            cyc();
        end
        clear_inputs();
        cyc();

        // Fetch held off by memory for three cycles, then accepted.
        if_req = 1; if_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_hold", {mem_req, mem_addr, mem_be, if_gnt}, {1'b1, 32'h200, 4'hF, 1'b0});
            end_cyc();
        end
        mem_gnt = 1;
        #1;
        chk("stall_gnt", {if_gnt, lsu_gnt}, 2'b10);
        end_cyc();

        // No response: error completion on the 5th cycle after grant.
        if_req = 0; mem_gnt = 0;
        for (int k = 1; k <= TMO; k++) begin
            #1;
            chk("tmo_wait", {if_rvalid, mem_req}, 2'b00);
            end_cyc();
        end
        #1;
        chk("tmo_err", {if_rvalid, if_err, if_rdata, lsu_rvalid}, {1'b1, 1'b1, 32'h0, 1'b0});
        end_cyc();
        lsu_req = 1; lsu_addr = 32'h300; lsu_be = 4'h3; lsu_we = 1; lsu_wdata = 32'hCAFE; mem_gnt = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("drain_no_gnt", {lsu_gnt, if_gnt, mem_req}, 3'b000);
            end_cyc();
        end
        mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
        #1;
        chk("drain_discard", {if_rvalid, lsu_rvalid, lsu_gnt}, 3'b000);
        end_cyc();
        mem_rvalid = 0;
        #1;
        chk("post_drain_gnt", {lsu_gnt, mem_we, mem_be}, {1'b1, 1'b1, 4'h3});
        end_cyc();

        // Reset while waiting, then the stale response arrives.
        lsu_req = 0; mem_gnt = 0; srst = 1;
        cyc();
        srst = 0; mem_rvalid = 1; mem_rdata = 32'h55;
        #1;
        chk("reset_ignores_resp", {lsu_rvalid, lsu_rdata, if_rvalid, mem_req}, 0);
        end_cyc();
        mem_rvalid = 0;

        // Response coinciding with the timeout wins.
        if_req = 1; if_addr = 32'h400; mem_gnt = 1;
        #1;
        chk("coin_gnt", if_gnt, 1'b1);
        end_cyc();
        if_req = 0; mem_gnt = 0;
        for (int k = 1; k <= TMO; k++) cyc();
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        #1;
        chk("coin_resp", {if_rvalid, if_err, if_rdata}, {1'b1, 1'b0, 32'h12345678});
        end_cyc();
        mem_rvalid = 0; lsu_req = 1; lsu_we = 0; lsu_addr = 32'h500; mem_gnt = 1;
        #1;
        chk("coin_next_idle", lsu_gnt, 1'b1);
        end_cyc();
        lsu_req = 0; mem_gnt = 0; mem_rvalid = 1;
        cyc();
        clear_inputs();

        // Randomized traffic; requesters hold req and payload until granted.
        for (int n = 0; n < 3000; n++) begin
            srst = ($urandom_range(99) == 0);
            if (!(if_req && !g_if)) begin
                if_req = $urandom_range(1);
                if_addr = $urandom;
            end
            if (!(lsu_req && !g_lsu)) begin
                lsu_req = $urandom_range(1);
                lsu_we = $urandom_range(1);
                lsu_be = 4'($urandom);
                lsu_addr = $urandom;
                lsu_wdata = $urandom;
            end
            mem_gnt = ($urandom_range(99) < 60);
            mem_rvalid = ($urandom_range(99) < 25);
            mem_rdata = $urandom;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
